// File: rtl/data_mem_responder_if.sv
// Request/response bundle between a pipeline MEM stage (master) and the
// data-memory responder (slave). Clock and reset travel as plain ports.
interface data_mem_responder_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqUnsigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic [31:0] RespRData;
  logic        RespErr;

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData,
    input  ReqReady, RespValid, RespRData, RespErr
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData,
    output ReqReady, RespValid, RespRData, RespErr
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder. Accepts one load/store at a time,
// waits LATENCY edges, performs a byte/half/word access on a word array and
// returns a one-cycle response carrying read data or an alignment error.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Size 11 is reserved; half needs Addr[0]=0; word needs Addr[1:0]=00.
  function automatic logic f_is_bad(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lo[0];
      2'b10:   bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Replace only the addressed little-endian lanes of the old word.
  function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                          input logic [31:0] wd,
                                          input logic [1:0]  size,
                                          input logic [1:0]  lo);
    logic [31:0] res;
    res = old_w;
    case (size)
      2'b00: begin
        case (lo)
          2'd0: res[7:0]   = wd[7:0];
          2'd1: res[15:8]  = wd[7:0];
          2'd2: res[23:16] = wd[7:0];
          default: res[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (lo[1]) res[31:16] = wd[15:0];
        else       res[15:0]  = wd[15:0];
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  // Select the addressed lanes, move them to the LSBs and extend.
  function automatic logic [31:0] f_extract(input logic [31:0] w,
                                            input logic [1:0]  size,
                                            input logic        uns,
                                            input logic [1:0]  lo);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    sh = w >> {lo, 3'b000};
    b  = sh[7:0];
    h  = lo[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = w;
    endcase
    return res;
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          w_access;
  logic          w_resp_err;
  logic          w_enter_resp;

  logic          r_write;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;

  logic [31:0]   r_rdata;
  logic          r_err;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_bad;
  logic          w_a_write;
  logic [1:0]    w_a_size;
  logic          w_a_uns;
  logic [AW+1:0] w_a_addr;
  logic [31:0]   w_a_wdata;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [31:0]   w_merged;
  logic [31:0]   w_load;

  assign w_accept = (r_state == IDLE) && bus.ReqValid;
  assign w_bad    = f_is_bad(bus.ReqSize, bus.ReqAddr[1:0]);

  // In IDLE the access (single-edge latency) uses the live request;
  // otherwise it uses the request captured at accept.
  assign w_a_write = (r_state == IDLE) ? bus.ReqWrite         : r_write;
  assign w_a_size  = (r_state == IDLE) ? bus.ReqSize          : r_size;
  assign w_a_uns   = (r_state == IDLE) ? bus.ReqUnsigned      : r_uns;
  assign w_a_addr  = (r_state == IDLE) ? bus.ReqAddr[AW+1:0]  : r_addr;
  assign w_a_wdata = (r_state == IDLE) ? bus.ReqWData         : r_wdata;

  assign w_idx    = w_a_addr[AW+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_merged = f_merge(w_word, w_a_wdata, w_a_size, w_a_addr[1:0]);
  assign w_load   = f_extract(w_word, w_a_size, w_a_uns, w_a_addr[1:0]);

  assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);

  assign bus.ReqReady  = (r_state == IDLE);
  assign bus.RespValid = (r_state == RESP);
  assign bus.RespRData = r_rdata;
  assign bus.RespErr   = r_err;

  // State and latency counter register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter and access/error strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    w_resp_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ReqValid) begin
          if (w_bad) begin
            w_state_nxt = RESP;
            w_cnt_nxt   = 4'd0;
            w_resp_err  = 1'b1;
          end else if (LATENCY == 1) begin
            w_state_nxt = RESP;
            w_cnt_nxt   = 4'd0;
            w_access    = 1'b1;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = RESP;
          w_access    = 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Capture the request fields at accept; later cycles read them back.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_write <= bus.ReqWrite;
      r_size  <= bus.ReqSize;
      r_uns   <= bus.ReqUnsigned;
      r_addr  <= bus.ReqAddr[AW+1:0];
      r_wdata <= bus.ReqWData;
    end
  end

  // Response registers: loaded entering RESP, cleared leaving it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata <= (w_access && !w_a_write) ? w_load : 32'd0;
      r_err   <= w_resp_err;
    end else if (r_state == RESP) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end
  end

  // Word array write port; contents are deliberately kept across reset,
  // but no store may land while reset is held.
  always_ff @(posedge Clk) begin
    if (Reset && w_access && w_a_write) begin
      r_mem[w_idx] <= w_merged;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with LATENCY=3 and one with
// LATENCY=1. Drivers push expected responses into per-instance queues; a
// negedge monitor pops and compares data, error flag and arrival cycle.
module tb_data_mem_responder;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  data_mem_responder_if if3();
  data_mem_responder_if if1();

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (
    .Clk(Clk), .Reset(Reset), .bus(if3)
  );
  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .bus(if1)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          due;
  } exp_t;

  exp_t q3[$];
  exp_t q1[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  function automatic logic rdy(input int which);
    return (which == 0) ? if3.ReqReady : if1.ReqReady;
  endfunction

  task automatic drive(input int which, input logic v, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] wd);
    if (which == 0) begin
      if3.ReqValid = v; if3.ReqWrite = w; if3.ReqSize = sz;
      if3.ReqUnsigned = u; if3.ReqAddr = a; if3.ReqWData = wd;
    end else begin
      if1.ReqValid = v; if1.ReqWrite = w; if1.ReqSize = sz;
      if1.ReqUnsigned = u; if1.ReqAddr = a; if1.ReqWData = wd;
    end
  endtask

  task automatic mon(input int which, input logic [31:0] rd, input logic err);
    exp_t e;
    if ((which == 0 && q3.size() == 0) || (which == 1 && q1.size() == 0)) begin
      n_chk++;
      $display("FAIL dut%0d unexpected_resp: got RespValid=1 rdata=0x%08h err=%0b, expected no response",
               which, rd, err);
      return;
    end
    e = (which == 0) ? q3.pop_front() : q1.pop_front();
    chk($sformatf("dut%0d rdata", which), rd, e.rd);
    chk($sformatf("dut%0d err", which), {31'd0, err}, {31'd0, e.err});
    chk($sformatf("dut%0d resp_cycle", which), cyc, e.due);
  endtask

  // Response monitor.
  always @(negedge Clk) begin
    if (if3.RespValid) mon(0, if3.RespRData, if3.RespErr);
    if (if1.RespValid) mon(1, if1.RespRData, if1.RespErr);
  end

  // One complete request: wait for ready, present for one cycle, scramble
  // inputs afterwards, and check how long ReqReady stays low.
  task automatic req(input int which, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    int   n;
    int   lat;
    exp_t e;
    lat = (which == 0) ? 3 : 1;
    @(negedge Clk);
    n = 0;
    while (!rdy(which) && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!rdy(which)) begin
      chk($sformatf("dut%0d ready_timeout", which), {31'd0, rdy(which)}, 32'd1);
      return;
    end
    drive(which, 1'b1, w, sz, u, a, wd);
    @(posedge Clk);
    #1;
    e.rd  = exp_rd;
    e.err = exp_err;
    e.due = cyc + (exp_err ? 0 : lat - 1);
    if (which == 0) q3.push_back(e);
    else            q1.push_back(e);
    drive(which, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
    n = 0;
    @(negedge Clk);
    while (!rdy(which) && n < 40) begin
      n++;
      @(negedge Clk);
    end
    chk($sformatf("dut%0d ready_low_cycles @%08h", which, a), n, exp_err ? 1 : lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);

    // Asynchronous reset between clock edges.
    #2 Reset = 1'b0;
    #1;
    chk("rst dut3 ReqReady",  {31'd0, if3.ReqReady},  32'd1);
    chk("rst dut3 RespValid", {31'd0, if3.RespValid}, 32'd0);
    chk("rst dut3 RespRData", if3.RespRData,          32'd0);
    chk("rst dut3 RespErr",   {31'd0, if3.RespErr},   32'd0);
    chk("rst dut1 ReqReady",  {31'd0, if1.ReqReady},  32'd1);
    chk("rst dut1 RespValid", {31'd0, if1.RespValid}, 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;

    // Word store/load and sub-word lanes, LATENCY=3.
    req(0, 1, 2'b10, 0, 32'h40, 32'hDEADBEEF, 32'h0,        0);
    req(0, 0, 2'b10, 0, 32'h40, 32'h0,        32'hDEADBEEF, 0);
    req(0, 1, 2'b00, 0, 32'h41, 32'hABCDEF80, 32'h0,        0);
    req(0, 0, 2'b10, 0, 32'h40, 32'h0,        32'hDEAD80EF, 0);
    req(0, 0, 2'b00, 0, 32'h41, 32'h0,        32'hFFFFFF80, 0);
    req(0, 0, 2'b00, 1, 32'h41, 32'h0,        32'h00000080, 0);
    req(0, 1, 2'b01, 0, 32'h42, 32'h00001234, 32'h0,        0);
    req(0, 0, 2'b10, 0, 32'h40, 32'h0,        32'h123480EF, 0);
    req(0, 0, 2'b01, 0, 32'h40, 32'h0,        32'hFFFF80EF, 0);
    req(0, 0, 2'b01, 1, 32'h42, 32'h0,        32'h00001234, 0);
    req(0, 0, 2'b00, 1, 32'h43, 32'h0,        32'h00000012, 0);
    req(0, 0, 2'b00, 0, 32'h40, 32'h0,        32'hFFFFFFEF, 0);

    // Alignment and reserved-size errors; memory must be untouched.
    req(0, 0, 2'b10, 0, 32'h42, 32'h0,        32'h0,        1);
    req(0, 1, 2'b01, 0, 32'h43, 32'h0000FFFF, 32'h0,        1);
    req(0, 0, 2'b11, 0, 32'h40, 32'h0,        32'h0,        1);
    req(0, 0, 2'b10, 0, 32'h40, 32'h0,        32'h123480EF, 0);

    // Aliasing with single-edge latency.
    req(1, 1, 2'b10, 0, 32'h1000, 32'h00000055, 32'h0,        0);
    req(1, 0, 2'b10, 0, 32'h0,    32'h0,        32'h00000055, 0);
    req(1, 0, 2'b00, 0, 32'h1000, 32'h0,        32'h00000055, 0);

    // Reset while a store is pending: dropped, no response.
    req(0, 1, 2'b10, 0, 32'h80, 32'h22222222, 32'h0, 0);
    @(negedge Clk);
    drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h80, 32'h11111111);
    @(posedge Clk);
    #1 drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("busy_rst ReqReady",  {31'd0, if3.ReqReady},  32'd1);
    chk("busy_rst RespValid", {31'd0, if3.RespValid}, 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (5) @(negedge Clk);
    req(0, 0, 2'b10, 0, 32'h80, 32'h0, 32'h22222222, 0);

    repeat (10) @(negedge Clk);
    chk("dut3 queue_empty", q3.size(), 32'd0);
    chk("dut1 queue_empty", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder for the MEM stage of the 5-stage pipeline. It accepts one load/store request at a time over a valid/ready handshake, holds it for a programmable latency, and then performs the word, halfword or byte access on its internal word array. It returns a single-cycle response with read data or an alignment error. The pipeline stalls on `ReqReady`/`RespValid`, which replaces the zero-latency array as the data-memory endpoint.

## Interface
- `DEPTH_WORDS`, 1024 — number of 32-bit words; must be a power of two ≥ 4.
- `LATENCY`, 3 — number of clock edges from accept to `RespValid`; legal range 1–15.
- `Clk` in 1 — single clock; all state updates on the rising edge.
- `Reset` in 1 — asynchronous, active-low; asserting it forces the reset state immediately.
- `ReqValid` in 1 — request present.
- `ReqReady` out 1 — block can accept; equals (state == IDLE).
- `ReqWrite` in 1 — 1 = store, 0 = load.
- `ReqSize` in 2 — 00 byte, 01 halfword, 10 word, 11 reserved.
- `ReqUnsigned` in 1 — on loads, 1 = zero-extend, 0 = sign-extend (ignored for words and stores).
- `ReqAddr` in 32 — byte address.
- `ReqWData` in 32 — store data, right-justified (byte in [7:0], half in [15:0]).
- `RespValid` out 1 — one-cycle response strobe.
- `RespRData` out 32 — load result; 0 for stores and errors.
- `RespErr` out 1 — misaligned or reserved-size request; valid with `RespValid`.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: `ReqReady`=1. On `ReqValid`, latch Write, Size, Unsigned, Addr and WData, and load the counter.
  - Request is bad (Size=11, half with Addr[0]=1, or word with Addr[1:0]≠00): go to RESP with err=1; memory untouched.
  - Otherwise with `LATENCY`=1: go directly to RESP, performing the access on that edge.
  - Otherwise: go to BUSY with counter = `LATENCY`−1.
- BUSY: counter decrements each edge. On the edge where the counter is 1, perform the access and go to RESP.
- RESP: `RespValid`=1 for exactly one cycle; next edge returns to IDLE. `ReqValid` is ignored in BUSY and RESP.
- Index = latched Addr[log2(`DEPTH_WORDS`)+1:2]; upper address bits are ignored, so addresses alias modulo 4·`DEPTH_WORDS`.
- Stores replace only the addressed lanes:
  - byte lane = Addr[1:0];
  - half lane = Addr[1] (low half at 0);
  - word replaces all lanes;
  - little-endian lane order.
- Loads select the same lanes, shift them to the LSBs, and extend per `ReqUnsigned`/size.
- Response registers (`RespRData`, `RespErr`) are loaded on the edge entering RESP and cleared to 0 on the edge leaving RESP.
- Memory array is not reset; its contents survive `Reset`.

## Timing
- Reset values: state IDLE, `ReqReady`=1, `RespValid`=0, `RespRData`=0, `RespErr`=0, counter 0.
- Accept on edge N:
  - good request: `RespValid` is high in the cycle after edge N+`LATENCY`−1, i.e. `LATENCY` edges after accept;
  - error: `RespValid` is high in the cycle after edge N.
- Store takes effect on the edge entering RESP. A load accepted in the cycle after that RESP observes the new data.
- Maximum throughput is one request per `LATENCY`+1 cycles. `ReqReady` returns to 1 in the cycle after RESP.
- Request inputs need only be valid in the accept cycle.
- `Reset` asserted in BUSY: pending store is dropped with memory unchanged, and no response is produced. `Reset` asserted in RESP: `RespValid` drops immediately (asynchronous).
- `ReqValid` held high continuously: requests are accepted at every IDLE cycle. There is no combinational path from `ReqValid` to `ReqReady`.

## Test plan
- Reset then idle: `Reset`=0 mid-cycle → all outputs 0 except `ReqReady`=1, immediately and without a clock edge.
- Word store/load, `LATENCY`=3:
  - store 0xDEADBEEF at 0x40 → `RespValid` 3 edges after accept, `RespRData`=0;
  - load 0x40 → `RespRData`=0xDEADBEEF, `RespErr`=0;
  - `ReqReady`=0 for 3 cycles each.
- Sub-word lanes:
  - store byte 0x80 at 0x41 → word at 0x40 reads 0xDEAD80EF;
  - signed byte load at 0x41 → 0xFFFFFF80; unsigned → 0x00000080;
  - half store 0x1234 at 0x42 → word reads 0x123480EF.
- Alignment errors:
  - word load at 0x42 → `RespErr`=1 one edge after accept, `RespRData`=0;
  - half store at 0x43 → `RespErr`=1, memory unchanged.
- Aliasing and `LATENCY`=1: with `DEPTH_WORDS`=1024, store 0x55 at 0x1000 then load 0x0 → 0x55, each response one edge after accept.
- Reset mid-BUSY: store 0x11111111 to 0x80 and assert `Reset` one cycle after accept → no `RespValid`; subsequent load of 0x80 returns the prior contents.
